// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: sequencer states, requester ids,
// performance counter width and a saturating increment helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports plus the memory-side bus of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_LEN  = 8
);
    logic                 req0;
    logic                 we0;
    logic [ADDR_LEN-1:0]  addr0;
    logic [WORD_SIZE-1:0] wdata0;
    logic                 ack0;
    logic                 err0;

    logic                 req1;
    logic                 we1;
    logic [ADDR_LEN-1:0]  addr1;
    logic [WORD_SIZE-1:0] wdata1;
    logic                 ack1;
    logic                 err1;

    logic [WORD_SIZE-1:0] rdata;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_LEN-1:0]  mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, err0, ack1, err1, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, err0, ack1, err1, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone eligible requester wins outright,
// a tie goes to the requester rr_ptr_i points at.
module rr_arb2 (
    input  logic [1:0] eligible_i,
    input  logic       rr_ptr_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_valid_o = |eligible_i;
        gnt_id_o    = 1'b0;
        if (&eligible_i) begin
            gnt_id_o = rr_ptr_i;
        end else begin
            gnt_id_o = eligible_i[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port data memory between the CPU
// and a debug port. Define DMEM_ARBITER_PERF_CNT_EN to add grant/wait counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_LEN  = 8,
    parameter int MEM_SIZE  = 256
) (
    input  logic clk,
    input  logic rst,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARBITER_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_gnt0,
    output logic [CNT_W-1:0] cnt_gnt1,
    output logic [CNT_W-1:0] cnt_wait
`endif
);

    arb_state_e           state_q, state_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic                 gnt_id_q, gnt_id_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 err0_q, err0_d;
    logic                 err1_q, err1_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_LEN-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;

    logic [1:0]           eligible;
    logic                 gnt_valid;
    logic                 gnt_id;
    logic                 sel_we;
    logic [ADDR_LEN-1:0]  sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata;
    logic [ADDR_LEN:0]    sel_addr_ext;
    logic                 sel_oor;

    // A port whose ack is showing still has its req up; it must not be granted again.
    assign eligible = {bus.req1 & ~ack1_q, bus.req0 & ~ack0_q};

    rr_arb2 u_rr_arb2 (
        .eligible_i  (eligible),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    assign sel_we       = (gnt_id == REQ_DBG) ? bus.we1    : bus.we0;
    assign sel_addr     = (gnt_id == REQ_DBG) ? bus.addr1  : bus.addr0;
    assign sel_wdata    = (gnt_id == REQ_DBG) ? bus.wdata1 : bus.wdata0;
    assign sel_addr_ext = {1'b0, sel_addr};
    assign sel_oor      = sel_addr_ext >= (ADDR_LEN+1)'(MEM_SIZE);

    // The mem_addr/mem_wdata registers double as the request latches for the access.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_id_d    = gnt_id_q;
        we_d        = we_q;
        err_d       = err_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    gnt_id_d = gnt_id;
                    we_d     = sel_we;
                    err_d    = sel_oor;
                    if (sel_oor) begin
                        state_d = RESP;
                    end else begin
                        state_d     = ACCESS;
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                rdata_d  = (we_q || err_q) ? '0 : bus.mem_rdata;
                ack0_d   = (gnt_id_q == REQ_CPU);
                ack1_d   = (gnt_id_q == REQ_DBG);
                err0_d   = err_q && (gnt_id_q == REQ_CPU);
                err1_d   = err_q && (gnt_id_q == REQ_DBG);
                rr_ptr_d = ~gnt_id_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            gnt_id_q    <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            we_q        <= we_d;
            err_q       <= err_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.err0      = err0_q;
    assign bus.err1      = err1_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef DMEM_ARBITER_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_gnt0_q, cnt_gnt1_q, cnt_wait_q;
    logic             gnt0_now, gnt1_now, wait_now;

    // A wait is either the losing side of an IDLE tie or the other port's req during a busy cycle.
    always_comb begin
        gnt0_now = (state_q == IDLE) && gnt_valid && (gnt_id == REQ_CPU);
        gnt1_now = (state_q == IDLE) && gnt_valid && (gnt_id == REQ_DBG);
        if (state_q == IDLE) begin
            wait_now = &eligible;
        end else begin
            wait_now = (gnt_id_q == REQ_CPU) ? bus.req1 : bus.req0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_gnt0_q <= '0;
            cnt_gnt1_q <= '0;
            cnt_wait_q <= '0;
        end else begin
            if (gnt0_now) cnt_gnt0_q <= sat_inc(cnt_gnt0_q);
            if (gnt1_now) cnt_gnt1_q <= sat_inc(cnt_gnt1_q);
            if (wait_now) cnt_wait_q <= sat_inc(cnt_wait_q);
        end
    end

    assign cnt_gnt0 = cnt_gnt0_q;
    assign cnt_gnt1 = cnt_gnt1_q;
    assign cnt_wait = cnt_wait_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, contention and reset
// sequences, then randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int MEM_SIZE = 200;

    logic clk = 1'b0;
    logic rst;
    logic loadMem;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.WORD_SIZE(8), .ADDR_LEN(8)) bus ();

`ifdef DMEM_ARBITER_PERF_CNT_EN
    logic [15:0] cnt_gnt0, cnt_gnt1, cnt_wait;
`endif

    dmem_arbiter #(
        .WORD_SIZE (8),
        .ADDR_LEN  (8),
        .MEM_SIZE  (MEM_SIZE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DMEM_ARBITER_PERF_CNT_EN
        ,
        .cnt_gnt0 (cnt_gnt0),
        .cnt_gnt1 (cnt_gnt1),
        .cnt_wait (cnt_wait)
`endif
    );

    function automatic logic [7:0] memInit(input int i);
        if (i == 16) return 8'hA5;
        return 8'(i * 37 + 11);
    endfunction

    // Synchronous single-port memory with one-cycle read latency
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (loadMem) begin
            for (int i = 0; i < 256; i++) mem[i] <= memInit(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int         enCnt = 0;
    int         weCnt = 0;
    logic [7:0] lastEnAddr = 8'h00;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            enCnt      <= enCnt + 1;
            lastEnAddr <= bus.mem_addr;
            if (bus.mem_we) weCnt <= weCnt + 1;
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".ack0"}, 32'(bus.ack0), 0);
        checkOutput({tag, ".ack1"}, 32'(bus.ack1), 0);
        checkOutput({tag, ".err0"}, 32'(bus.err0), 0);
        checkOutput({tag, ".err1"}, 32'(bus.err1), 0);
        checkOutput({tag, ".rdata"}, 32'(bus.rdata), 0);
        checkOutput({tag, ".memEn"}, 32'(bus.mem_en), 0);
        checkOutput({tag, ".memWe"}, 32'(bus.mem_we), 0);
        checkOutput({tag, ".memAddr"}, 32'(bus.mem_addr), 0);
        checkOutput({tag, ".memWdata"}, 32'(bus.mem_wdata), 0);
    endtask

    int         resLat [2];
    logic [7:0] resRd [2];
    logic       resErr [2];
    int         strayAck;

    // Raise the requested ports together, drop each req as its ack shows, record latency/data
    task automatic applyStimulus(input logic [1:0] act, input logic w0, input logic w1,
                                 input logic [7:0] a0, input logic [7:0] a1,
                                 input logic [7:0] d0, input logic [7:0] d1, input bit scramble);
        logic [1:0] pend;
        @(posedge clk); #1;
        bus.req0 = act[0]; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = act[1]; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        pend = act;
        strayAck = 0;
        resLat[0] = 0; resLat[1] = 0;
        for (int k = 1; k <= 24 && pend != 2'b00; k++) begin
            @(posedge clk); #1;
            if (bus.ack0 && !pend[0]) strayAck++;
            if (bus.ack1 && !pend[1]) strayAck++;
            if (pend[0] && bus.ack0) begin
                resLat[0] = k; resRd[0] = bus.rdata; resErr[0] = bus.err0;
                pend[0] = 1'b0; bus.req0 = 1'b0;
            end
            if (pend[1] && bus.ack1) begin
                resLat[1] = k; resRd[1] = bus.rdata; resErr[1] = bus.err1;
                pend[1] = 1'b0; bus.req1 = 1'b0;
            end
            if (scramble && k == 1) begin
                bus.we0 = ~bus.we0; bus.addr0 = ~bus.addr0; bus.wdata0 = ~bus.wdata0;
                bus.we1 = ~bus.we1; bus.addr1 = ~bus.addr1; bus.wdata1 = ~bus.wdata1;
            end
        end
        checkOutput("ackTimeout", 32'(pend), 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk); #1;
        checkOutput("ackPulseOneCycle", 32'({bus.ack0, bus.ack1}), 0);
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] expRd;
        bit         expErr;
        int         expLat;
        int         expEn;
        int         expWe;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] refMem [256];
    bit         refPtr;

    initial begin
        int         e0, w0c, p, first, t, grantK, ackK;
        bit         errE;
        logic [1:0] act, w;
        logic [7:0] aR [2];
        logic [7:0] dR [2];
        logic [7:0] expRd;

        rst = 1'b1; loadMem = 1'b0;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
        for (int i = 0; i < 256; i++) refMem[i] = memInit(i);

        vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 3, 1, 0};
        vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'h00, 1'b0, 3, 1, 1};
        vecs[2] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h3C, 1'b0, 3, 1, 0};
        vecs[3] = '{1'b0, 1'b1, 8'hC7, 8'h5A, 8'h00, 1'b0, 3, 1, 1};
        vecs[4] = '{1'b1, 1'b0, 8'hC7, 8'h00, 8'h5A, 1'b0, 3, 1, 0};
        vecs[5] = '{1'b1, 1'b1, 8'hC8, 8'h77, 8'h00, 1'b1, 2, 0, 0};
        vecs[6] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 2, 0, 0};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h0B, 1'b0, 3, 1, 0};
        vecs[8] = '{1'b0, 1'b0, 8'hC8, 8'h00, 8'h00, 1'b1, 2, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        loadMem = 1'b1;
        @(posedge clk); #1;
        loadMem = 1'b0;
        rst = 1'b0;

        // Directed single-port vectors
        for (int i = 0; i < 9; i++) begin
            e0 = enCnt; w0c = weCnt; p = int'(vecs[i].port);
            applyStimulus(vecs[i].port ? 2'b10 : 2'b01, vecs[i].we, vecs[i].we,
                          vecs[i].addr, vecs[i].addr, vecs[i].wdata, vecs[i].wdata, 1'b0);
            checkOutput($sformatf("vec%0d.rdata", i), 32'(resRd[p]), 32'(vecs[i].expRd));
            checkOutput($sformatf("vec%0d.err", i), 32'(resErr[p]), 32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d.latency", i), 32'(resLat[p]), 32'(vecs[i].expLat));
            checkOutput($sformatf("vec%0d.memEnCycles", i), 32'(enCnt - e0), 32'(vecs[i].expEn));
            checkOutput($sformatf("vec%0d.memWeCycles", i), 32'(weCnt - w0c), 32'(vecs[i].expWe));
            checkOutput($sformatf("vec%0d.strayAck", i), 32'(strayAck), 0);
            if (vecs[i].expEn != 0)
                checkOutput($sformatf("vec%0d.memAddr", i), 32'(lastEnAddr), 32'(vecs[i].addr));
            if (vecs[i].we && !vecs[i].expErr) refMem[vecs[i].addr] = vecs[i].wdata;
        end
        checkOutput("oorWriteDropped", 32'(mem[200]), 32'(memInit(200)));

        // Requester changes after the grant must not affect the access
        applyStimulus(2'b01, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1);
        checkOutput("scramble.rdata", 32'(resRd[0]), 32'hA5);
        checkOutput("scramble.err", 32'(resErr[0]), 0);
        checkOutput("scramble.latency", 32'(resLat[0]), 3);

        // Both reqs held continuously after reset: acks alternate 0,1,0,1 three cycles apart
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("rr.k%0d.ack0", k), 32'(bus.ack0), 32'(k == 3 || k == 9));
            checkOutput($sformatf("rr.k%0d.ack1", k), 32'(bus.ack1), 32'(k == 6 || k == 12));
            if (k == 3 || k == 9) checkOutput($sformatf("rr.k%0d.rdata", k), 32'(bus.rdata), 32'hA5);
            if (k == 6 || k == 12) checkOutput($sformatf("rr.k%0d.rdata", k), 32'(bus.rdata), 32'h3C);
        end
`ifdef DMEM_ARBITER_PERF_CNT_EN
        checkOutput("cnt.gnt0", 32'(cnt_gnt0), 2);
        checkOutput("cnt.gnt1", 32'(cnt_gnt1), 2);
        checkOutput("cnt.waitNonZero", 32'(cnt_wait != 0), 1);
`endif
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // Serve port 0 so the pointer favours port 1, then reset in the middle of its access
        applyStimulus(2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        checkOutput("preRst.rdata", 32'(resRd[0]), 32'h0B);
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        @(posedge clk); #1;
        checkOutput("midRst.memEn", 32'(bus.mem_en), 1);
        checkOutput("midRst.memAddr", 32'(bus.mem_addr), 32'h20);
        rst = 1'b1;
        #1;
        checkResetState("midRst");
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("inRst.k%0d.acks", k), 32'({bus.ack0, bus.ack1}), 0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("postRst.k%0d.ack0", k), 32'(bus.ack0), 32'(k == 3));
            checkOutput($sformatf("postRst.k%0d.ack1", k), 32'(bus.ack1), 32'(k == 6));
            if (k == 3) checkOutput("postRst.rdata0", 32'(bus.rdata), 32'hA5);
            if (k == 6) checkOutput("postRst.rdata1", 32'(bus.rdata), 32'h3C);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // Randomized traffic against a transaction-level model of service order and timing
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        refPtr = 1'b0;
        for (int n = 0; n < 80; n++) begin
            act = 2'($urandom_range(1, 3));
            w = 2'($urandom);
            aR[0] = 8'($urandom); aR[1] = 8'($urandom);
            dR[0] = 8'($urandom); dR[1] = 8'($urandom);
            applyStimulus(act, w[0], w[1], aR[0], aR[1], dR[0], dR[1], 1'b0);
            checkOutput($sformatf("rand%0d.strayAck", n), 32'(strayAck), 0);
            first = (act == 2'b11) ? int'(refPtr) : int'(act[1]);
            t = 0;
            for (int j = 0; j < 2; j++) begin
                p = (j == 0) ? first : 1 - first;
                if (act[p]) begin
                    errE = (int'(aR[p]) >= MEM_SIZE);
                    grantK = (t == 0) ? 1 : t + 1;
                    ackK = grantK + (errE ? 1 : 2);
                    expRd = (w[p] || errE) ? 8'h00 : refMem[aR[p]];
                    if (w[p] && !errE) refMem[aR[p]] = dR[p];
                    refPtr = (p == 0);
                    t = ackK;
                    checkOutput($sformatf("rand%0d.p%0d.rdata", n, p), 32'(resRd[p]), 32'(expRd));
                    checkOutput($sformatf("rand%0d.p%0d.err", n, p), 32'(resErr[p]), 32'(errE));
                    checkOutput($sformatf("rand%0d.p%0d.latency", n, p), 32'(resLat[p]), 32'(ackK));
                end
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (MEM_SIZE x WORD_SIZE, one-cycle synchronous read) between two requesters.
  - Port 0: CPU memory stage.
  - Port 1: debug/loader port, so a bench or host can read and write data memory while the CPU runs.
- Round-robin arbitration with a req/ack handshake and a 3-state access sequencer.
- Sits between the CPU's memory-stage interface and the memory instance, inside the CPU top.

Parameters:
- WORD_SIZE, 8, data width of memory words.
- ADDR_LEN, 8, address width.
- MEM_SIZE, 256, number of valid words; addresses >= MEM_SIZE are out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0 / req1  in  1  access request; held until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_LEN  word address.
- wdata0 / wdata1  in  WORD_SIZE  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  valid with ack; 1 = address out of range.
- rdata  out  WORD_SIZE  read data; valid while ack0 or ack1 is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_LEN  memory address.
- mem_wdata  out  WORD_SIZE  memory write data.
- mem_rdata  in  WORD_SIZE  memory read data, valid the cycle after mem_en.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0.
  - ack0/1=0, err0/1=0, rdata=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Any access in flight is abandoned with no ack. A write already strobed stays in memory.
- All outputs are registered, so none are combinational from inputs.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Eligible requester = req high AND its ack not high this cycle. This masks the trailing req of the requester just served.
  - One eligible requester: grant it.
  - Both eligible: grant the one rr_ptr points to.
  - On grant, latch we/addr/wdata and the grant id, then go to ACCESS.
  - If the latched addr >= MEM_SIZE, go to RESP directly with err flagged and no memory access.
- ACCESS (one cycle): mem_en=1; mem_we, mem_addr and mem_wdata come from the latches. Next state RESP.
- RESP (one cycle):
  - mem_en=0.
  - At the closing edge: register rdata = mem_rdata (reads) or 0 (writes and errors); set ack of the granted port for one cycle, plus its err if flagged.
  - Set rr_ptr = the other port. Next state IDLE.
- Latency: req sampled at edge E0 -> memory strobed at E1 -> ack visible after E2.
  - Per-access cost is 3 cycles.
  - Back-to-back sustained throughput is 1 access per 3 cycles.
- Requester-side changes to we/addr/wdata after the grant are ignored.
- Dropping req before ack is a protocol violation. The access still completes and acks.
- Fairness: with both reqs held continuously, grants alternate 0,1,0,1. Neither port waits more than one access.
- req=0 on both ports: stay in IDLE, mem_en=0.

Optional Feature:
- Macro: DMEM_ARBITER_PERF_CNT_EN.
- When defined, adds three outputs:
  - cnt_gnt0 (16 bits): grants to port 0.
  - cnt_gnt1 (16 bits): grants to port 1.
  - cnt_wait (16 bits): cycles in which an eligible requester was not granted, i.e. any non-IDLE cycle with another req pending, or the losing port in IDLE.
- All three reset to 0 and saturate at 16'hFFFF.
- Undefined: the ports and logic do not exist. Functional behaviour is identical either way.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - requester ids (REQ_CPU=0, REQ_DBG=1);
  - counter width constant (16).
- One sub-module, rr_arb2: combinational 2-way round-robin pick from (eligible[1:0], rr_ptr) -> (gnt_valid, gnt_id). It is reused later for instruction-memory sharing.

Test Plan:
- Single read: mem[0x10]=0xA5; req0=1, we0=0, addr0=0x10 -> mem_en high exactly one cycle with mem_addr=0x10; ack0 pulses 3 cycles after sampling with rdata=0xA5, err0=0; ack1 stays 0.
- Write then read: port 1 writes 0x3C to 0x20, then port 0 reads 0x20 -> second ack0 carries rdata=0x3C; mem_we high only during the write's ACCESS cycle.
- Contention: req0 and req1 held together for 4 accesses after reset -> grant order 0,1,0,1 (ack pattern ack0, ack1, ack0, ack1), 3 cycles apart; no double-grant to the port whose ack is high.
- Out of range: instance with MEM_SIZE=200; req1 with addr1=0xC8 -> mem_en never asserts; ack1 and err1 pulse 2 cycles after sampling; rdata=0.
- Reset mid-access: assert rst during ACCESS -> all outputs 0 immediately, no ack; after release, a pending req0 is served normally with rr_ptr=0.
- With DMEM_ARBITER_PERF_CNT_EN: run the contention scenario -> cnt_gnt0=2, cnt_gnt1=2, cnt_wait>0; force 70000 grants -> cnt_gnt0 saturates at 0xFFFF.
